// File: rtl/uart_led_ctrl.sv
// Multi-channel LED controller driven by opcodes from the UART receiver.
// Each channel supports set, clear, toggle and a shared-phase free-running blink.
module uart_led_ctrl #(
  parameter int         NUM_LEDS          = 4,
  parameter int         BLINK_HALF_PERIOD = 25_000_000,
  parameter logic [7:0] LEGACY_OPCODE     = 8'h55
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_done_flag,
  input  logic [7:0]          opcode,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] blink_active,
  output logic                cmd_ack,
  output logic                cmd_err
);

  localparam int             CNT_W   = $clog2(BLINK_HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_HALF_PERIOD - 1);
  localparam logic [3:0]     NUM_CH  = 4'(NUM_LEDS);
  localparam logic [3:0]     CH_ALL  = 4'hF;

  localparam logic [3:0] CMD_SET    = 4'h1;
  localparam logic [3:0] CMD_CLEAR  = 4'h2;
  localparam logic [3:0] CMD_TOGGLE = 4'h3;
  localparam logic [3:0] CMD_BLINK  = 4'h4;

  typedef enum logic {STATIC = 1'b0, BLINK = 1'b1} mode_t;

  mode_t                mode_q [NUM_LEDS];
  mode_t                mode_d [NUM_LEDS];
  logic [NUM_LEDS-1:0]  led_d;
  logic [NUM_LEDS-1:0]  hit;
  logic [CNT_W-1:0]     cnt;
  logic                 flag_d;
  logic                 tick;
  logic                 evt;
  logic                 is_legacy;
  logic                 cmd_ok;
  logic                 ch_ok;
  logic                 accept;
  logic                 reject;
  logic [3:0]           cmd;
  logic [3:0]           ch;

  // Never cleared by commands, so every blinking channel shares phase boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_MAX);

  always_comb begin
    evt       = rx_done_flag & ~flag_d;
    cmd       = opcode[7:4];
    ch        = opcode[3:0];
    is_legacy = (opcode == LEGACY_OPCODE);
    cmd_ok    = (cmd >= CMD_SET) && (cmd <= CMD_BLINK);
    ch_ok     = (ch == CH_ALL) || (ch < NUM_CH);
    accept    = evt & (is_legacy | (cmd_ok & ch_ok));
    reject    = evt & ~accept;
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (is_legacy) begin
        hit[i] = (i == 0);
      end else begin
        hit[i] = (ch == CH_ALL) || (ch == 4'(i));
      end
    end
  end

  // A command on an addressed channel overrides that channel's blink tick.
  always_comb begin
    led_d = led;
    for (int i = 0; i < NUM_LEDS; i++) begin
      mode_d[i] = mode_q[i];
      if (tick && (mode_q[i] == BLINK)) begin
        led_d[i] = ~led[i];
      end
      if (accept && hit[i]) begin
        if (is_legacy) begin
          mode_d[i] = STATIC;
          led_d[i]  = ~led[i];
        end else begin
          case (cmd)
            CMD_SET: begin
              mode_d[i] = STATIC;
              led_d[i]  = 1'b1;
            end
            CMD_CLEAR: begin
              mode_d[i] = STATIC;
              led_d[i]  = 1'b0;
            end
            CMD_TOGGLE: begin
              mode_d[i] = STATIC;
              led_d[i]  = ~led[i];
            end
            CMD_BLINK: begin
              mode_d[i] = BLINK;
              led_d[i]  = 1'b1;
            end
            default: begin
              mode_d[i] = mode_q[i];
            end
          endcase
        end
      end
    end
  end

  // flag_d resets high so a flag already asserted at reset release is not a command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_d  <= 1'b1;
      led     <= '0;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i] <= STATIC;
      end
    end else begin
      flag_d  <= rx_done_flag;
      led     <= led_d;
      cmd_ack <= accept;
      cmd_err <= reject;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i] <= mode_d[i];
      end
    end
  end

  always_comb begin
    blink_active = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      blink_active[i] = (mode_q[i] == BLINK);
    end
  end

endmodule

// File: doc/uart_led_ctrl.md
Name: uart_led_ctrl

Overview:
Multi-channel LED controller driven by opcodes from the UART receiver. It generalises the single-LED opcode toggle to NUM_LEDS channels, each with set, clear, toggle and free-running blink. It sits between the UART RX block (rx_done_flag, opcode byte) and the board LED pins. Per-command ack and error pulses feed status logic.

Parameters:
NUM_LEDS, 4, number of LED channels; legal range 1..15.
BLINK_HALF_PERIOD, 25_000_000, clk cycles per blink half-period; must be >= 2.
LEGACY_OPCODE, 8'h55, opcode that toggles channel 0. Kept for backward compatibility with existing host software.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
rx_done_flag  input  1  level flag from UART RX; a new byte is signalled by its rising edge.
opcode  input  8  received byte; stable while rx_done_flag is high.
led  output  NUM_LEDS  registered LED drive; bit i is channel i.
blink_active  output  NUM_LEDS  registered; bit i = 1 when channel i is in BLINK mode.
cmd_ack  output  1  one-cycle pulse; a command was accepted and applied.
cmd_err  output  1  one-cycle pulse; a command was rejected and caused no state change.

Behaviour:
- Reset (async assert, synchronous-edge release):
  - led = 0, blink_active = 0, cmd_ack = 0, cmd_err = 0.
  - Prescaler = 0.
  - Edge-detect register flag_d = 1, so a flag already high at reset release does not produce a command.
- Edge detect: evt = rx_done_flag & ~flag_d. flag_d <= rx_done_flag every cycle.
- Latency: on the clock edge where evt = 1, the opcode is decoded and applied.
  - led, blink_active and cmd_ack/cmd_err update on that same edge, so they are visible 1 cycle after the flag rises.
  - A flag held high produces exactly one command.
- Decode:
  - If opcode == LEGACY_OPCODE, toggle channel 0: channel 0 goes to STATIC, led[0] inverts, ack.
  - Otherwise cmd = opcode[7:4] and ch = opcode[3:0]. ch = 4'hF targets all channels.
  - cmd 1 SET: mode STATIC, led = 1.
  - cmd 2 CLEAR: mode STATIC, led = 0.
  - cmd 3 TOGGLE: mode STATIC, led inverts.
  - cmd 4 BLINK: mode BLINK, led = 1 immediately. Re-issuing BLINK to a channel already blinking restarts its phase at 1.
  - cmd 0 and cmd 5..F (other than LEGACY_OPCODE) are rejected: cmd_err, no change.
  - ch >= NUM_LEDS and ch != F is rejected: cmd_err, no change.
- Per-channel mode FSM, two states:
  - STATIC -> BLINK on a BLINK command.
  - BLINK -> STATIC on SET, CLEAR, TOGGLE or the legacy opcode.
  - blink_active mirrors the state.
- Prescaler:
  - Free-running, counts 0..BLINK_HALF_PERIOD-1 and wraps to 0.
  - tick = 1 when count == BLINK_HALF_PERIOD-1.
  - Width is clog2(BLINK_HALF_PERIOD).
  - It is never reset by commands, so all blinking channels share phase boundaries.
- On tick, every channel in BLINK inverts led.
- Simultaneous tick and command in the same cycle:
  - The command wins for the addressed channel(s).
  - Tick still applies to the other blinking channels.
- cmd_ack and cmd_err are mutually exclusive and low in all cycles without evt.
- Opcode is sampled only in the evt cycle; changes at any other time are ignored.

Test Plan:
Use BLINK_HALF_PERIOD = 4 and NUM_LEDS = 4 for all scenarios.
1. Reset check: hold rx_done_flag high through rst release -> no ack, no err, led = 4'b0000. Then drop the flag, raise it with opcode 8'h55 -> led = 4'b0001 one cycle later and cmd_ack pulses for exactly 1 cycle.
2. Basic commands: send 0x12, then 0x32, then 0x22 -> led[2] reads 1, 0, 0 after each respective command. Hold rx_done_flag high for 10 cycles -> only one ack.
3. Blink: send 0x41 -> led[1] = 1 and blink_active = 4'b0010. Then led[1] inverts on every tick, exactly 4 cycles apart. Send 0x11 -> blink_active = 0 and led[1] = 1 stays constant.
4. Broadcast: send 0x4F, then 0x2F -> all four LEDs blink in phase, then all go to 0 with blink_active = 0.
5. Errors: send 0x14 (ch 4 >= NUM_LEDS), 0x03 and 0x77 -> cmd_err pulses each time and led/blink_active do not change.
6. Collision: with channels 0 and 3 blinking, send 0x20 timed so evt coincides with tick -> led[0] = 0 and STATIC, while led[3] still inverts. Assert rst mid-blink -> all outputs 0 immediately, asynchronously.
